mc_control_unit: RTL
====================

// Module: mc_control_unit
// PURPOSE
//  Multicycle RV32I control FSM driving a shared-memory multicycle datapath.
//  Successor to single-cycle decode: one instruction over several states, one unified memory.
//  Generalised with variable-latency memory handshake (mem_ready), watchdog timeout, and
//  a sticky TRAP state for illegal opcodes. Datapath regs/muxes live outside this block.
// PARAMETERS
//  TIMEOUT_CYCLES  16  max consecutive mem_ready=0 cycles in a memory state before TRAP
//  CNT_W           5   wait-counter width; must satisfy 2**CNT_W > TIMEOUT_CYCLES
// PORTS
//  clk         in   1  clock
//  rst         in   1  reset, synchronous, active-high
//  op          in   7  Instr[6:0] (IR output)
//  funct3      in   3  Instr[14:12]
//  funct7_b5   in   1  Instr[30]
//  zero        in   1  ALU zero flag
//  mem_ready   in   1  memory completed access this cycle
//  PCWrite     out  1  PC register enable
//  AdrSrc      out  1  mem address: 0=PC, 1=ALUOut
//  MemRead     out  1  memory read request
//  MemWrite    out  1  memory write request
//  IRWrite     out  1  instruction/OldPC register enable
//  ResultSrc   out  2  00=ALUOut, 01=Data, 10=ALUResult
//  ALUSrcA     out  2  00=PC, 01=OldPC, 10=RD1
//  ALUSrcB     out  2  00=RD2, 01=ImmExt, 10=const 4
//  ALUControl  out  3  000 add,001 sub,010 and,011 or,101 slt
//  ImmSrc      out  2  00 I, 01 S, 10 B, 11 J
//  RegWrite    out  1  register-file write enable
//  instr_done  out  1  one-cycle pulse on transition back to FETCH
//  illegal     out  1  sticky: TRAP entered via unknown opcode/funct3
//  mem_timeout out  1  sticky: TRAP entered via watchdog
//  state       out  4  current state encoding (debug)
// BEHAVIOUR
//  States: FETCH=0 DECODE=1 MEMADR=2 MEMREAD=3 MEMWB=4 MEMWRITE=5 EXECR=6 ALUWB=7
//   EXECI=8 JAL=9 BRANCH=10 TRAP=11. Reset -> FETCH, wait cnt=0, illegal=mem_timeout=0.
//  While rst=1: PCWrite,IRWrite,RegWrite,MemWrite,MemRead,instr_done all 0.
//  FETCH: AdrSrc=0 MemRead=1 A=00 B=10 add ResultSrc=10; IRWrite=PCWrite=mem_ready;
//   mem_ready=1 -> DECODE else stay.
//  DECODE: A=01 B=01 add (branch target). op 0x03/0x23->MEMADR, 0x33->EXECR, 0x13->EXECI,
//   0x6F->JAL, 0x63->BRANCH, other->TRAP(illegal=1).
//  MEMADR: A=10 B=01 add; op 0x03->MEMREAD, 0x23->MEMWRITE.
//  MEMREAD: AdrSrc=1 MemRead=1 ResultSrc=00; mem_ready -> MEMWB. MEMWB: ResultSrc=01 RegWrite=1 -> FETCH.
//  MEMWRITE: AdrSrc=1 MemWrite=1 ResultSrc=00; mem_ready -> FETCH.
//  EXECR: A=10 B=00 ALUOp=R. EXECI: A=10 B=01 ALUOp=R. Both -> ALUWB.
//  ALUWB: ResultSrc=00 RegWrite=1 -> FETCH.
//  JAL: A=01 B=10 add ResultSrc=00 PCWrite=1 -> ALUWB (rd=PC+4).
//  BRANCH: A=10 B=00 sub ResultSrc=00; funct3=000: PCWrite=zero; else TRAP(illegal) -> FETCH.
//  ImmSrc decoded from op in every state: 0x23->01, 0x63->10, 0x6F->11, else 00.
//  ALU decode (ALUOp=R): f3 000: sub iff op[5]&funct7_b5 else add; 010 slt; 110 or; 111 and;
//   other f3 -> TRAP(illegal) from EXECR/EXECI instead of ALUWB.
//  Watchdog: in FETCH/MEMREAD/MEMWRITE, cnt++ each mem_ready=0 cycle, clears on state
//   change; cnt==TIMEOUT_CYCLES-1 with mem_ready=0 -> TRAP, mem_timeout=1. mem_ready wins.
//  TRAP: all enables 0, MemRead=0; exits only via rst. Reset mid-instruction -> FETCH.
//  instr_done=1 in the cycle whose next state is FETCH (not from TRAP).
//  Unlisted outputs are 0 in each state. Outputs are Moore except mem_ready/zero gating.
// CONFIGURATION
//  RV_BNE_EN defined: BRANCH with funct3=001 decodes bne, PCWrite=~zero, -> FETCH.
//  RV_BNE_EN undefined: funct3=001 in BRANCH -> TRAP, illegal=1.
// TESTING
//  addi 0x00600413, mem_ready=1 -> FETCH,DECODE,EXECI,ALUWB; ALUControl=000, RegWrite=1 in ALUWB, 4 cycles.
//  sub 0x409409B3 -> EXECR ALUControl=001, ALUWB RegWrite=1; and f3=111 -> 010.
//  lw 0x00002403, mem_ready low 3 cycles in MEMREAD -> MEMREAD held 4 cycles, MEMWB RegWrite=1, ResultSrc=01.
//  beq zero=1 -> PCWrite=1 in BRANCH, ALUControl=001; zero=0 -> PCWrite=0; 3 cycles total.
//  mem_ready=0 held in FETCH 16 cycles -> state=11, mem_timeout=1, all enables 0 until rst.
//  op=0x7F -> TRAP, illegal=1; bne f3=001 zero=0 -> PCWrite=1 iff RV_BNE_EN, else illegal=1.

Source files
------------

// File: rtl/mc_control_unit.sv
// mc_control_unit: multicycle RV32I control FSM for a shared-memory datapath.
// The memory handshake is variable-latency (mem_ready). A watchdog limits how long
// a memory state may wait. TRAP is a sticky sink: only rst leaves it.
// Optional feature macro: RV_BNE_EN (decode bne in BRANCH when defined).
// The parameters must satisfy 2**CNT_W > TIMEOUT_CYCLES.
module mc_control_unit #(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int CNT_W          = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7_b5,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       PCWrite,
  output logic       AdrSrc,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [2:0] ALUControl,
  output logic [1:0] ImmSrc,
  output logic       RegWrite,
  output logic       instr_done,
  output logic       illegal,
  output logic       mem_timeout,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_ALUWB    = 4'd7,
    S_EXECI    = 4'd8,
    S_JAL      = 4'd9,
    S_BRANCH   = 4'd10,
    S_TRAP     = 4'd11
  } state_t;

  localparam logic [6:0] OP_LOAD   = 7'h03;
  localparam logic [6:0] OP_STORE  = 7'h23;
  localparam logic [6:0] OP_RTYPE  = 7'h33;
  localparam logic [6:0] OP_ITYPE  = 7'h13;
  localparam logic [6:0] OP_JAL    = 7'h6F;
  localparam logic [6:0] OP_BRANCH = 7'h63;

  // Last counter value at which a still-missing mem_ready trips the watchdog.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_t           state_r;
  state_t           next_s;
  logic [CNT_W-1:0] cnt_r;
  logic             illegal_r;
  logic             mem_timeout_r;

  logic             set_illegal_s;
  logic             set_timeout_s;
  logic             wait_expired_s;
  logic             in_mem_state_s;
  logic [2:0]       alu_dec_s;
  logic             alu_ok_s;
  logic             pc_write_s;
  logic             adr_src_s;
  logic             mem_read_s;
  logic             mem_write_s;
  logic             ir_write_s;
  logic [1:0]       result_src_s;
  logic [1:0]       alu_src_a_s;
  logic [1:0]       alu_src_b_s;
  logic [2:0]       alu_control_s;
  logic             reg_write_s;
  logic             instr_done_s;

  // Immediate format follows the opcode alone, independent of state.
  function automatic logic [1:0] imm_sel(input logic [6:0] opc);
    logic [1:0] sel;
    case (opc)
      OP_STORE:  sel = 2'b01;
      OP_BRANCH: sel = 2'b10;
      OP_JAL:    sel = 2'b11;
      default:   sel = 2'b00;
    endcase
    return sel;
  endfunction

  // R/I-type ALU operation decode; unsupported funct3 is flagged as not ok.
  always_comb begin
    alu_dec_s = 3'b000;
    alu_ok_s  = 1'b1;
    case (funct3)
      3'b000: begin
        // op[5] distinguishes R-type from I-type: addi never subtracts.
        if (op[5] & funct7_b5) begin
          alu_dec_s = 3'b001;
        end else begin
          alu_dec_s = 3'b000;
        end
      end
      3'b010:  alu_dec_s = 3'b101;
      3'b110:  alu_dec_s = 3'b011;
      3'b111:  alu_dec_s = 3'b010;
      default: alu_ok_s  = 1'b0;
    endcase
  end

  // Watchdog trips only when the last allowed wait cycle also lacks mem_ready.
  always_comb begin
    in_mem_state_s = (state_r == S_FETCH) || (state_r == S_MEMREAD) || (state_r == S_MEMWRITE);
    wait_expired_s = (cnt_r == CNT_LAST) && !mem_ready;
  end

  // Next-state selection and Moore outputs (mem_ready/zero gate the enables).
  always_comb begin
    next_s        = state_r;
    pc_write_s    = 1'b0;
    adr_src_s     = 1'b0;
    mem_read_s    = 1'b0;
    mem_write_s   = 1'b0;
    ir_write_s    = 1'b0;
    result_src_s  = 2'b00;
    alu_src_a_s   = 2'b00;
    alu_src_b_s   = 2'b00;
    alu_control_s = 3'b000;
    reg_write_s   = 1'b0;
    set_illegal_s = 1'b0;
    set_timeout_s = 1'b0;
    case (state_r)
      S_FETCH: begin
        mem_read_s   = 1'b1;
        alu_src_b_s  = 2'b10;
        result_src_s = 2'b10;
        ir_write_s   = mem_ready;
        pc_write_s   = mem_ready;
        if (mem_ready) begin
          next_s = S_DECODE;
        end else if (wait_expired_s) begin
          next_s        = S_TRAP;
          set_timeout_s = 1'b1;
        end else begin
          next_s = S_FETCH;
        end
      end
      S_DECODE: begin
        // Precompute the branch target OldPC + imm while decoding.
        alu_src_a_s = 2'b01;
        alu_src_b_s = 2'b01;
        case (op)
          OP_LOAD, OP_STORE: next_s = S_MEMADR;
          OP_RTYPE:          next_s = S_EXECR;
          OP_ITYPE:          next_s = S_EXECI;
          OP_JAL:            next_s = S_JAL;
          OP_BRANCH:         next_s = S_BRANCH;
          default: begin
            next_s        = S_TRAP;
            set_illegal_s = 1'b1;
          end
        endcase
      end
      S_MEMADR: begin
        alu_src_a_s = 2'b10;
        alu_src_b_s = 2'b01;
        case (op)
          OP_LOAD:  next_s = S_MEMREAD;
          OP_STORE: next_s = S_MEMWRITE;
          default: begin
            next_s        = S_TRAP;
            set_illegal_s = 1'b1;
          end
        endcase
      end
      S_MEMREAD: begin
        adr_src_s  = 1'b1;
        mem_read_s = 1'b1;
        if (mem_ready) begin
          next_s = S_MEMWB;
        end else if (wait_expired_s) begin
          next_s        = S_TRAP;
          set_timeout_s = 1'b1;
        end else begin
          next_s = S_MEMREAD;
        end
      end
      S_MEMWB: begin
        result_src_s = 2'b01;
        reg_write_s  = 1'b1;
        next_s       = S_FETCH;
      end
      S_MEMWRITE: begin
        adr_src_s   = 1'b1;
        mem_write_s = 1'b1;
        if (mem_ready) begin
          next_s = S_FETCH;
        end else if (wait_expired_s) begin
          next_s        = S_TRAP;
          set_timeout_s = 1'b1;
        end else begin
          next_s = S_MEMWRITE;
        end
      end
      S_EXECR, S_EXECI: begin
        alu_src_a_s   = 2'b10;
        alu_src_b_s   = (state_r == S_EXECI) ? 2'b01 : 2'b00;
        alu_control_s = alu_dec_s;
        if (alu_ok_s) begin
          next_s = S_ALUWB;
        end else begin
          next_s        = S_TRAP;
          set_illegal_s = 1'b1;
        end
      end
      S_ALUWB: begin
        reg_write_s = 1'b1;
        next_s      = S_FETCH;
      end
      S_JAL: begin
        // Jump to the target computed in DECODE; ALU forms the link PC+4.
        alu_src_a_s = 2'b01;
        alu_src_b_s = 2'b10;
        pc_write_s  = 1'b1;
        next_s      = S_ALUWB;
      end
      S_BRANCH: begin
        alu_src_a_s   = 2'b10;
        alu_control_s = 3'b001;
        if (funct3 == 3'b000) begin
          pc_write_s = zero;
          next_s     = S_FETCH;
`ifdef RV_BNE_EN
        end else if (funct3 == 3'b001) begin
          pc_write_s = !zero;
          next_s     = S_FETCH;
`endif
        end else begin
          next_s        = S_TRAP;
          set_illegal_s = 1'b1;
        end
      end
      S_TRAP: begin
        next_s = S_TRAP;
      end
      default: begin
        next_s = S_TRAP;
      end
    endcase
  end

  // Completion pulse: leaving a non-FETCH, non-TRAP state towards FETCH.
  always_comb begin
    instr_done_s = (next_s == S_FETCH) && (state_r != S_FETCH) && (state_r != S_TRAP);
  end

  // State, watchdog counter and sticky trap-cause flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r       <= S_FETCH;
      cnt_r         <= '0;
      illegal_r     <= 1'b0;
      mem_timeout_r <= 1'b0;
    end else begin
      state_r <= next_s;
      if (in_mem_state_s && (next_s == state_r)) begin
        cnt_r <= cnt_r + CNT_ONE;
      end else begin
        cnt_r <= '0;
      end
      if (set_illegal_s) begin
        illegal_r <= 1'b1;
      end else begin
        illegal_r <= illegal_r;
      end
      if (set_timeout_s) begin
        mem_timeout_r <= 1'b1;
      end else begin
        mem_timeout_r <= mem_timeout_r;
      end
    end
  end

  // Enables are forced low while reset is asserted.
  assign PCWrite     = pc_write_s   & ~rst;
  assign MemRead     = mem_read_s   & ~rst;
  assign MemWrite    = mem_write_s  & ~rst;
  assign IRWrite     = ir_write_s   & ~rst;
  assign RegWrite    = reg_write_s  & ~rst;
  assign instr_done  = instr_done_s & ~rst;
  assign AdrSrc      = adr_src_s;
  assign ResultSrc   = result_src_s;
  assign ALUSrcA     = alu_src_a_s;
  assign ALUSrcB     = alu_src_b_s;
  assign ALUControl  = alu_control_s;
  assign ImmSrc      = imm_sel(op);
  assign illegal     = illegal_r;
  assign mem_timeout = mem_timeout_r;
  assign state       = state_r;

endmodule
